// File: rtl/mod_pipe_if.sv
// Streaming interface of the constant-divisor modulo/quotient pipeline.
//
// Handshake: an input sample transfers on a rising edge where
// i_valid && o_ready; an output sample transfers on a rising edge where
// o_valid && i_ready. A producer holds i_valid and its data until the
// transfer. The block holds o_valid and its data until the transfer.
// o_ready is a combinational function of i_ready.
interface mod_pipe_if #(
   parameter int DIVIDEND_W = 16,
   parameter int DIVIDER    = 12,
   parameter int TAG_W      = 8
);
   localparam int RES_W = $clog2(DIVIDER);

   logic                  i_valid;
   logic                  o_ready;
   logic [DIVIDEND_W-1:0] i_dividend;
   logic [TAG_W-1:0]      i_tag;
   logic                  o_valid;
   logic                  i_ready;
   logic [DIVIDEND_W-1:0] o_quotient;
   logic [RES_W-1:0]      o_result;
   logic [TAG_W-1:0]      o_tag;

   // Block side: consumes samples, produces results.
   modport slave (
      input  i_valid, i_dividend, i_tag, i_ready,
      output o_ready, o_valid, o_quotient, o_result, o_tag
   );

   // Environment side: produces samples, consumes results.
   modport master (
      output i_valid, i_dividend, i_tag, i_ready,
      input  o_ready, o_valid, o_quotient, o_result, o_tag
   );
endinterface

// File: rtl/mod_pipe.sv
// Pipelined Q = floor(X / D), R = X mod D for a compile-time divisor D.
// S1 multiplies X by a ceiling reciprocal to estimate Q. S2 back-multiplies
// to form a signed remainder estimate. S3 applies the single correction.
// With FRAC >= DIVIDEND_W the estimate is Q or Q+1, so S3 only ever has to
// step down once, and only when the remainder estimate is negative.
// FRAC must be at least DIVIDEND_W; smaller values break exactness.
module mod_pipe #(
   parameter int DIVIDEND_W = 16,
   parameter int DIVIDER    = 12,
   parameter int FRAC       = DIVIDEND_W + 4,
   parameter int TAG_W      = 8
) (
   input logic       i_clk,
   input logic       i_rst,
   mod_pipe_if.slave bus
);
   localparam int RES_W = $clog2(DIVIDER);
   localparam int PW    = DIVIDEND_W + FRAC + 1;

   // RECIP = ceil(2^FRAC / D), evaluated at elaboration in FRAC+2 bits.
   localparam logic [FRAC+1:0] POW2    = {2'b01, {FRAC{1'b0}}};
   localparam logic [FRAC+1:0] D_F     = (FRAC+2)'(DIVIDER);
   localparam logic [FRAC+1:0] RECIP_F = (POW2 + D_F - (FRAC+2)'(1)) / D_F;
   localparam logic [FRAC:0]   RECIP   = (FRAC+1)'(RECIP_F);
   localparam logic [DIVIDEND_W:0] D_R = (DIVIDEND_W+1)'(DIVIDER);

   // Global enable: every stage moves together unless the output is
   // blocked. This makes o_ready combinational on i_ready.
   logic en;

   logic                  s1_valid;
   logic [DIVIDEND_W-1:0] s1_x;
   logic [TAG_W-1:0]      s1_tag;
   logic [DIVIDEND_W-1:0] s1_q;

   logic                  s2_valid;
   logic [TAG_W-1:0]      s2_tag;
   logic [DIVIDEND_W-1:0] s2_q;
   logic [DIVIDEND_W:0]   s2_r;

   logic                  s3_valid;
   logic [DIVIDEND_W-1:0] s3_q;
   logic [RES_W-1:0]      s3_r;
   logic [TAG_W-1:0]      s3_tag;

   logic [PW-1:0]         s1_p;
   logic [DIVIDEND_W-1:0] s1_q_in;
   logic [DIVIDEND_W:0]   s2_bd;
   logic [DIVIDEND_W:0]   s2_r_in;
   logic                  s3_neg;
   logic [DIVIDEND_W:0]   s3_r_fix;
   logic [DIVIDEND_W-1:0] s3_q_in;
   logic [RES_W-1:0]      s3_r_in;

   assign en          = !s3_valid || bus.i_ready;
   assign bus.o_ready = en;

   // Quotient estimate: the product never exceeds DIVIDEND_W bits after the
   // shift because the reciprocal overshoot is below 2^-FRAC per unit of X.
   assign s1_p    = PW'(bus.i_dividend) * PW'(RECIP);
   assign s1_q_in = DIVIDEND_W'(s1_p >> FRAC);

   // Remainder estimate lies in (-D, D); one extra bit carries the sign.
   assign s2_bd   = {1'b0, s1_q} * D_R;
   assign s2_r_in = {1'b0, s1_x} - s2_bd;

   // Correction: a negative estimate means q_est was Q+1.
   assign s3_neg   = s2_r[DIVIDEND_W];
   assign s3_r_fix = s2_r + D_R;
   assign s3_q_in  = s3_neg ? (s2_q - DIVIDEND_W'(1)) : s2_q;
   assign s3_r_in  = s3_neg ? RES_W'(s3_r_fix) : RES_W'(s2_r);

   // S1: capture the sample and its quotient estimate.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         s1_valid <= 1'b0;
         s1_x     <= '0;
         s1_tag   <= '0;
         s1_q     <= '0;
      end else if (en) begin
         s1_valid <= bus.i_valid;
         s1_x     <= bus.i_dividend;
         s1_tag   <= bus.i_tag;
         s1_q     <= s1_q_in;
      end
   end

   // S2: register the signed remainder estimate alongside q_est.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         s2_valid <= 1'b0;
         s2_tag   <= '0;
         s2_q     <= '0;
         s2_r     <= '0;
      end else if (en) begin
         s2_valid <= s1_valid;
         s2_tag   <= s1_tag;
         s2_q     <= s1_q;
         s2_r     <= s2_r_in;
      end
   end

   // S3: corrected result, held on the outputs while downstream stalls.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         s3_valid <= 1'b0;
         s3_q     <= '0;
         s3_r     <= '0;
         s3_tag   <= '0;
      end else if (en) begin
         s3_valid <= s2_valid;
         s3_q     <= s3_q_in;
         s3_r     <= s3_r_in;
         s3_tag   <= s2_tag;
      end
   end

   assign bus.o_valid    = s3_valid;
   assign bus.o_quotient = s3_q;
   assign bus.o_result   = s3_r;
   assign bus.o_tag      = s3_tag;
endmodule

// File: tb/tb_mod_pipe.sv
// Bench for mod_pipe: directed vectors, stalls, mid-stream reset, and a
// partial sweep on two extra instances (minimum FRAC and D=30).
module tb_mod_pipe;
   localparam int W  = 16;
   localparam int TW = 8;
   localparam int EW = TW + W + 8;

   // ---------------- clock / reset ----------------
   logic i_clk = 1'b0;
   logic i_rst;
   logic aux_rst;
   always #5 i_clk = ~i_clk;

   mod_pipe_if #(.DIVIDEND_W(W), .DIVIDER(12), .TAG_W(TW)) bus   ();
   mod_pipe_if #(.DIVIDEND_W(W), .DIVIDER(12), .TAG_W(TW)) bus16 ();
   mod_pipe_if #(.DIVIDEND_W(W), .DIVIDER(30), .TAG_W(TW)) bus30 ();

   mod_pipe #(.DIVIDEND_W(W), .DIVIDER(12), .FRAC(W + 4), .TAG_W(TW)) dut (
      .i_clk (i_clk), .i_rst (i_rst), .bus (bus)
   );
   mod_pipe #(.DIVIDEND_W(W), .DIVIDER(12), .FRAC(W), .TAG_W(TW)) dut16 (
      .i_clk (i_clk), .i_rst (aux_rst), .bus (bus16)
   );
   mod_pipe #(.DIVIDEND_W(W), .DIVIDER(30), .FRAC(W), .TAG_W(TW)) dut30 (
      .i_clk (i_clk), .i_rst (aux_rst), .bus (bus30)
   );

   // ---------------- checking ----------------
   int checks   = 0;
   int failures = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   function automatic logic [EW-1:0] model(input logic [TW-1:0] tag, input int x, input int d);
      logic [W-1:0] q;
      logic [7:0]   r;
      q = W'(x / d);
      r = 8'(x % d);
      return {tag, q, r};
   endfunction

   // ---------------- scoreboards ----------------
   logic [EW-1:0] exp_q[$];
   logic [EW-1:0] exp16_q[$];
   logic [EW-1:0] exp30_q[$];
   logic [EW-1:0] head;
   logic [EW-1:0] head16;
   logic [EW-1:0] head30;
   int r_viol    = 0;
   int corr16    = 0;

   // Main instance: the head entry must be on the outputs for every cycle
   // o_valid is high, which also covers stability during stalls.
   always @(negedge i_clk) begin
      if (i_rst) begin
         exp_q.delete();
      end else begin
         if (bus.o_valid) begin
            if (exp_q.size() == 0) begin
               check("out_expected", 32'(exp_q.size()), 1);
            end else begin
               head = exp_q[0];
               check("sb_tag", 32'(bus.o_tag), 32'(head[EW-1 -: TW]));
               check("sb_q", 32'(bus.o_quotient), 32'(head[W+7 -: W]));
               check("sb_r", 32'(bus.o_result), 32'(head[7:0]));
               if (bus.i_ready) void'(exp_q.pop_front());
            end
         end
         if (bus.i_valid && bus.o_ready)
            exp_q.push_back(model(bus.i_tag, int'(bus.i_dividend), 12));
      end
   end

   // Auxiliary instances run with i_ready held high.
   always @(negedge i_clk) begin
      if (!aux_rst) begin
         if (bus16.o_valid) begin
            if (exp16_q.size() == 0) begin
               check("f16_out_expected", 32'(exp16_q.size()), 1);
            end else begin
               head16 = exp16_q.pop_front();
               check("f16_tag", 32'(bus16.o_tag), 32'(head16[EW-1 -: TW]));
               check("f16_q", 32'(bus16.o_quotient), 32'(head16[W+7 -: W]));
               check("f16_r", 32'(bus16.o_result), 32'(head16[7:0]));
            end
         end
         if (bus16.i_valid && bus16.o_ready)
            exp16_q.push_back(model(bus16.i_tag, int'(bus16.i_dividend), 12));
         if (bus30.o_valid) begin
            if (exp30_q.size() == 0) begin
               check("d30_out_expected", 32'(exp30_q.size()), 1);
            end else begin
               head30 = exp30_q.pop_front();
               check("d30_tag", 32'(bus30.o_tag), 32'(head30[EW-1 -: TW]));
               check("d30_q", 32'(bus30.o_quotient), 32'(head30[W+7 -: W]));
               check("d30_r", 32'(bus30.o_result), 32'(head30[7:0]));
            end
         end
         if (bus30.i_valid && bus30.o_ready)
            exp30_q.push_back(model(bus30.i_tag, int'(bus30.i_dividend), 30));
      end
   end

   // Remainder estimate must never reach D (only the negative case is corrected).
   always @(negedge i_clk) begin
      if (dut.s2_valid && !dut.s2_r[W] && dut.s2_r >= 17'd12) r_viol++;
      if (dut16.s2_valid && !dut16.s2_r[W] && dut16.s2_r >= 17'd12) r_viol++;
      if (dut30.s2_valid && !dut30.s2_r[W] && dut30.s2_r >= 17'd30) r_viol++;
      if (dut16.s2_valid && dut16.s2_r[W]) corr16++;
   end

   // Random downstream backpressure when enabled.
   logic rand_rdy = 1'b0;
   initial begin
      forever begin
         @(posedge i_clk);
         #1;
         if (rand_rdy) bus.i_ready = 1'($urandom_range(1));
      end
   end

   // ---------------- driver tasks ----------------
   task automatic send(input logic [W-1:0] x, input logic [TW-1:0] tag);
      logic acc;
      int   n;
      bus.i_valid    = 1'b1;
      bus.i_dividend = x;
      bus.i_tag      = tag;
      acc = 1'b0;
      n   = 0;
      while (!acc && n < 1000) begin
         @(negedge i_clk);
         acc = bus.o_ready;
         @(posedge i_clk);
         #1;
         n++;
      end
      if (!acc) check("send_timeout", 32'(n), 0);
      bus.i_valid = 1'b0;
   endtask

   // Drive a back-to-back burst (i_ready = 1) and check hand-computed
   // outputs plus the latency of the first sample, counting the accepting
   // edge as cycle 1.
   task automatic burst(input string name, input int n_in, input int xs[4], input int qs[4],
                        input int rs[4], input int tag0);
      int first_seen;
      int oi;
      first_seen = -1;
      oi = 0;
      for (int k = 0; k < n_in + 5; k++) begin
         if (k < n_in) begin
            bus.i_valid    = 1'b1;
            bus.i_dividend = W'(xs[k]);
            bus.i_tag      = TW'(tag0 + k);
         end else begin
            bus.i_valid = 1'b0;
         end
         @(posedge i_clk);
         #1;
         if (bus.o_valid) begin
            if (first_seen < 0) first_seen = k + 1;
            if (oi < n_in) begin
               check($sformatf("%s_q%0d", name, oi), 32'(bus.o_quotient), 32'(qs[oi]));
               check($sformatf("%s_r%0d", name, oi), 32'(bus.o_result), 32'(rs[oi]));
               check($sformatf("%s_tag%0d", name, oi), 32'(bus.o_tag), 32'(tag0 + oi));
            end
            oi++;
         end
      end
      check($sformatf("%s_latency", name), 32'(first_seen), 3);
      check($sformatf("%s_count", name), 32'(oi), 32'(n_in));
   endtask

   // ---------------- stimulus ----------------
   int stale;
   int wait_n;
   int dx[4] = '{0, 11, 12, 65535};
   int dq[4] = '{0, 0, 1, 5461};
   int dr[4] = '{0, 11, 0, 3};
   int rx[4] = '{100, 0, 0, 0};
   int rq[4] = '{8, 0, 0, 0};
   int rr[4] = '{4, 0, 0, 0};

   initial begin
      i_rst   = 1'b1;
      aux_rst = 1'b1;
      bus.i_valid = 1'b0;   bus.i_dividend = '0;   bus.i_tag = '0;   bus.i_ready = 1'b1;
      bus16.i_valid = 1'b0; bus16.i_dividend = '0; bus16.i_tag = '0; bus16.i_ready = 1'b1;
      bus30.i_valid = 1'b0; bus30.i_dividend = '0; bus30.i_tag = '0; bus30.i_ready = 1'b1;
      repeat (3) @(posedge i_clk);
      #1;
      i_rst   = 1'b0;
      aux_rst = 1'b0;
      #1;
      check("rst_valid", 32'(bus.o_valid), 0);
      check("rst_q", 32'(bus.o_quotient), 0);
      check("rst_r", 32'(bus.o_result), 0);
      check("rst_tag", 32'(bus.o_tag), 0);
      check("rst_ready", 32'(bus.o_ready), 1);
      @(posedge i_clk);
      #1;

      fork
         begin
            // Directed back-to-back vectors.
            burst("dir", 4, dx, dq, dr, 0);

            // Mid-stream reset with three samples in flight.
            for (int k = 0; k < 3; k++) begin
               bus.i_valid    = 1'b1;
               bus.i_dividend = W'(100 * (k + 1));
               bus.i_tag      = TW'(20 + k);
               @(posedge i_clk);
               #1;
            end
            bus.i_valid = 1'b0;
            check("inflight_valid", 32'(bus.o_valid), 1);
            #1;
            i_rst = 1'b1;
            #1;
            check("arst_valid", 32'(bus.o_valid), 0);
            check("arst_q", 32'(bus.o_quotient), 0);
            check("arst_r", 32'(bus.o_result), 0);
            check("arst_tag", 32'(bus.o_tag), 0);
            repeat (2) @(posedge i_clk);
            #1;
            i_rst = 1'b0;
            stale = 0;
            repeat (5) begin
               @(posedge i_clk);
               #1;
               if (bus.o_valid) stale++;
            end
            check("no_stale", 32'(stale), 0);
            burst("post_rst", 1, rx, rq, rr, 8'h5a);

            // Random valid / ready over a few thousand samples.
            rand_rdy = 1'b1;
            for (int i = 0; i < 3000; i++) begin
               while ($urandom_range(1) == 0) begin
                  @(posedge i_clk);
                  #1;
               end
               send(W'($urandom_range(65535)), TW'(i));
            end
            send(16'd65535, 8'hee);
            rand_rdy = 1'b0;
            bus.i_ready = 1'b1;
            wait_n = 0;
            while (exp_q.size() != 0 && wait_n < 100) begin
               @(posedge i_clk);
               #1;
               wait_n++;
            end
            check("main_drain", 32'(exp_q.size()), 0);
         end
         begin
            // Sweep both ends of the range through the auxiliary instances.
            for (int i = 0; i < 4000; i++) begin
               bus16.i_valid    = 1'b1;
               bus30.i_valid    = 1'b1;
               bus16.i_dividend = (i < 2000) ? W'(i) : W'(65535 - (i - 2000));
               bus30.i_dividend = bus16.i_dividend;
               bus16.i_tag      = TW'(i);
               bus30.i_tag      = TW'(i);
               @(posedge i_clk);
               #1;
            end
            bus16.i_valid = 1'b0;
            bus30.i_valid = 1'b0;
            repeat (6) @(posedge i_clk);
            #1;
            check("f16_drain", 32'(exp16_q.size()), 0);
            check("d30_drain", 32'(exp30_q.size()), 0);
            check("f16_corrections_seen", 32'(corr16 > 0), 1);
         end
      join

      check("r_est_below_d", 32'(r_viol), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/mod_pipe.md
# mod_pipe

Pipelined, parametrised constant-divisor modulo/quotient unit: computes Q = floor(X / D) and R = X mod D for an unsigned X of configurable width, with a compile-time divisor D. It is the successor to the single-cycle combinational modulo used in the PUCCH index math (cyclic shift mod 12, sequence group mod 30, PRB mod 192, ...). The new block adds pipelining, a valid/ready handshake, a quotient output, a sideband tag, and an exact correction stage so results are correct for every input and every legal parameter set.

## Interface
- DIVIDEND_W, 16, width of X, Q and the internal remainder path (≥ 2)
- DIVIDER, 12, constant divisor D (2 ≤ D < 2^DIVIDEND_W)
- FRAC, DIVIDEND_W + 4, fractional bits of the internal reciprocal; legal range FRAC ≥ DIVIDEND_W
- TAG_W, 8, width of the sideband tag carried alongside each sample (≥ 1)
- Reciprocal is computed inside the block, not supplied: RECIP = ceil(2^FRAC / D), width FRAC + 1

Ports:
- i_clk  in  1  clock; all state on rising edge
- i_rst  in  1  reset, asynchronous, active-high
- i_valid  in  1  input sample valid
- o_ready  out  1  block accepts input this cycle
- i_dividend  in  DIVIDEND_W  X, unsigned
- i_tag  in  TAG_W  sideband, passed through unchanged
- o_valid  out  1  output sample valid
- i_ready  in  1  downstream accepts output
- o_quotient  out  DIVIDEND_W  Q = floor(X / D)
- o_result  out  clog2(D)  R = X mod D
- o_tag  out  TAG_W  tag of the same sample

## Operation
- Three register stages, S1 → S2 → S3; each stage holds valid, X, tag, plus stage-specific data.
- S1 (capture): register X and tag; compute P = X * RECIP (DIVIDEND_W + FRAC + 1 bits); q_est = P >> FRAC, truncated to DIVIDEND_W bits, and register it.
- S2 (back-multiply): r_est = X − q_est * D, computed signed in DIVIDEND_W + 1 bits; register r_est and q_est.
- S3 (correct): if r_est < 0, then R = r_est + D and Q = q_est − 1; otherwise R = r_est and Q = q_est. Register the result onto the outputs.
- Exactness: with the ceil reciprocal and FRAC ≥ DIVIDEND_W, q_est ∈ {Q, Q+1}, so a single negative correction suffices. The r_est ≥ D case cannot occur; the bench asserts this.
- X = 0 needs no special handling (q_est = 0, r_est = 0).
- Handshake and stall: a sample transfers in when i_valid && o_ready, and out when o_valid && i_ready.
  - Global pipeline enable: en = !o_valid || i_ready; o_ready = en.
  - When en = 0, every stage holds all of its contents. When en = 1, all stages advance; a stage with no valid data advances a bubble (valid = 0).
  - o_ready depends combinationally on i_ready (a documented path, no skid buffer).
- Outputs are held stable while o_valid && !i_ready.
- Reset (asynchronous assert, synchronous release via i_clk domain): all stage valids = 0, all data registers = 0. In-flight samples are discarded, not flushed.

## Timing
- Latency: 3 cycles from the accepting edge to o_valid, with no stall.
- Throughput: 1 sample/cycle while i_ready = 1.
- Reset values: o_valid = 0, o_quotient = 0, o_result = 0, o_tag = 0; o_ready = 1 from the first cycle after reset (o_valid is 0).
- Simultaneous output-consume and input-accept on the same edge is legal and loses no samples.
- Stall of N cycles delays each in-flight sample by exactly N cycles. No duplication, no loss, order preserved.
- Critical path: S1 multiplier (DIVIDEND_W × (FRAC+1)); S2 multiplier by the constant D. No combinational path from i_dividend to any output.

## Test plan
- D=12, W=16, default FRAC: X = 0, 11, 12, 65535 back-to-back → (Q,R) = (0,0), (0,11), (1,0), (5461,3); o_valid rises exactly 3 cycles after the first accept; tags 0..3 in order.
- D=12, W=16, FRAC=16 (minimum; RECIP=5462): X = 65531 → q_est 5461, correction fires, output (5460,11); X = 65532 → (5461,0).
- Exhaustive sweep X = 0..65535 for D ∈ {12, 24, 30, 192} at FRAC=16 and default; every (Q,R) matches the reference model; r_est ≥ D never observed.
- Random i_valid/i_ready (≈50% each) over 10k samples, D=30 → output stream equals input order with correct results; outputs and tags stable during every stall; e.g. X=65535 → (2184,15).
- Assert i_rst mid-stream with 3 samples in flight → o_valid falls asynchronously, all outputs 0; after release, the next accepted X=100 (D=12) yields (8,4) with latency 3 and no stale sample emitted.
